// File: rtl/graphics_type_pkg.sv
// graphics_type: vertex types shared across the 3D pipeline.
//   vertex_3d_t - model-space vertex (x, y, z), signed 16-bit each
//   vertex_2d_t - projected screen vertex (x, y), signed 16-bit each
package graphics_type;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vertex_3d_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } vertex_2d_t;

endpackage

// File: rtl/vertex_sequencer_bank.sv
// vertex_bank: double-buffered 2D vertex store.
//   clk, rst           - clock, synchronous active-high reset (zeroes both banks)
//   front_sel          - bank currently shown to the rasterizer
//   wr_en/wr_idx/wr_vert - write port, always into the back bank (!front_sel)
//   rd_idx/rd_vert     - combinational read from the front bank
module vertex_bank
  import graphics_type::*;
#(
  parameter int NUM_VERTS = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             front_sel,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  vertex_2d_t       wr_vert,
  input  logic [IDX_W-1:0] rd_idx,
  output vertex_2d_t       rd_vert
);

  vertex_2d_t mem_q [2][NUM_VERTS];
  vertex_2d_t mem_d [2][NUM_VERTS];

  // The front bank can never be the write target, so the rasterizer view
  // stays stable for the whole frame.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[~front_sel][wr_idx] = wr_vert;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_VERTS; i++)
          mem_q[b][i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_vert = mem_q[front_sel][rd_idx];

endmodule

// File: rtl/vertex_sequencer.sv
// vertex_sequencer: shares one rotate+project transform unit across all model
// vertices. A frame pulse accepted in IDLE latches model/angles, swaps banks
// if a finished batch is waiting, and issues vertices 0..NUM_VERTS-1. Results
// (any order, tagged by index) land in the back bank; done pulses after the
// last one.
//   frame, model_sel_in, angle_*_in    - frame start and requested setup
//   cfg_model_select, vtx_rd_idx/data  - scene_objects read side
//   xf_in_*, xf_ready, xf_angle_*      - transform issue side
//   xf_out_valid/idx/vert              - transform results
//   rd_idx/rd_vert                     - rasterizer front-bank read
//   busy, done, overrun                - status (overrun sticky until rst)
module vertex_sequencer
  import graphics_type::*;
#(
  parameter int NUM_VERTS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame,
  input  logic [1:0]          model_sel_in,
  input  logic signed [15:0]  angle_x_in,
  input  logic signed [15:0]  angle_y_in,
  input  logic signed [15:0]  angle_z_in,
  output logic [1:0]          cfg_model_select,
  output logic [IDX_W-1:0]    vtx_rd_idx,
  input  vertex_3d_t          vtx_rd_data,
  output logic                xf_in_valid,
  input  logic                xf_ready,
  output vertex_3d_t          xf_in_vert,
  output logic [IDX_W-1:0]    xf_in_idx,
  output logic signed [15:0]  xf_angle_x,
  output logic signed [15:0]  xf_angle_y,
  output logic signed [15:0]  xf_angle_z,
  input  logic                xf_out_valid,
  input  logic [IDX_W-1:0]    xf_out_idx,
  input  vertex_2d_t          xf_out_vert,
  input  logic [IDX_W-1:0]    rd_idx,
  output vertex_2d_t          rd_vert,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VERTS - 1);
  localparam logic [IDX_W:0]   ALL_WR   = (IDX_W + 1)'(NUM_VERTS);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [IDX_W:0]     wr_cnt_q, wr_cnt_d;
  logic               front_sel_q, front_sel_d;
  logic               back_valid_q, back_valid_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic [1:0]         model_q, model_d;
  logic signed [15:0] ang_x_q, ang_x_d, ang_y_q, ang_y_d, ang_z_q, ang_z_d;
  logic               wr_en;

  assign busy        = (state_q != S_IDLE);
  assign xf_in_valid = (state_q == S_ISSUE);
  assign vtx_rd_idx  = issue_cnt_q;
  assign xf_in_idx   = issue_cnt_q;
  assign xf_in_vert  = vtx_rd_data;

  // Results arriving while idle belong to no batch and are dropped.
  assign wr_en = xf_out_valid && busy;

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    front_sel_d  = front_sel_q;
    back_valid_d = back_valid_q;
    model_d      = model_q;
    ang_x_d      = ang_x_q;
    ang_y_d      = ang_y_q;
    ang_z_d      = ang_z_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;

    if (wr_en) wr_cnt_d = wr_cnt_q + 1'b1;
    // A frame while busy is refused; the running batch carries on untouched.
    if (frame && busy) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: if (frame) begin
        model_d = model_sel_in;
        ang_x_d = angle_x_in;
        ang_y_d = angle_y_in;
        ang_z_d = angle_z_in;
        if (back_valid_q) begin
          front_sel_d  = ~front_sel_q;
          back_valid_d = 1'b0;
        end
        issue_cnt_d = '0;
        wr_cnt_d    = '0;
        state_d     = S_ISSUE;
      end
      S_ISSUE: if (xf_ready) begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST_IDX) state_d = S_DRAIN;
      end
      // Looking at the next count lets done land the cycle after the final
      // writeback, with busy dropping in that same cycle.
      S_DRAIN: if (wr_cnt_d == ALL_WR) begin
        done_d       = 1'b1;
        back_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      issue_cnt_q  <= '0;
      wr_cnt_q     <= '0;
      front_sel_q  <= 1'b0;
      back_valid_q <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      model_q      <= '0;
      ang_x_q      <= '0;
      ang_y_q      <= '0;
      ang_z_q      <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      front_sel_q  <= front_sel_d;
      back_valid_q <= back_valid_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      model_q      <= model_d;
      ang_x_q      <= ang_x_d;
      ang_y_q      <= ang_y_d;
      ang_z_q      <= ang_z_d;
    end
  end

  assign cfg_model_select = model_q;
  assign xf_angle_x       = ang_x_q;
  assign xf_angle_y       = ang_y_q;
  assign xf_angle_z       = ang_z_q;
  assign done             = done_q;
  assign overrun          = overrun_q;

  vertex_bank #(.NUM_VERTS(NUM_VERTS), .IDX_W(IDX_W)) u_bank (
    .clk      (clk),
    .rst      (rst),
    .front_sel(front_sel_q),
    .wr_en    (wr_en),
    .wr_idx   (xf_out_idx),
    .wr_vert  (xf_out_vert),
    .rd_idx   (rd_idx),
    .rd_vert  (rd_vert)
  );

endmodule

// File: tb/tb_vertex_sequencer.sv
// Directed bench for vertex_sequencer: scene ROM + transform model (fixed
// latency, or full reversal), issue scoreboard, bank readback checks.
module tb_vertex_sequencer;
  import graphics_type::*;

  localparam int NV  = 8;
  localparam int IW  = 3;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst, frame;
  logic [1:0] model_sel_in, cfg_model_select;
  logic signed [15:0] angle_x_in, angle_y_in, angle_z_in;
  logic signed [15:0] xf_angle_x, xf_angle_y, xf_angle_z;
  logic [IW-1:0] vtx_rd_idx, xf_in_idx, xf_out_idx, rd_idx;
  vertex_3d_t vtx_rd_data, xf_in_vert;
  vertex_2d_t xf_out_vert, rd_vert;
  logic xf_in_valid, xf_ready, xf_out_valid, busy, done, overrun;

  always #20 clk = ~clk;

  typedef struct { logic [IW-1:0] idx; vertex_3d_t v; } exp_t;
  typedef struct { logic [IW-1:0] idx; vertex_2d_t v; int due; } res_t;

  exp_t sb[$];
  res_t pend[$];
  int ntest = 0, nfail = 0, cyc = 0, done_cyc = 0, t0 = 0;
  bit done_seen = 0, ooo = 0, ooo_emit = 0;
  int issue_cyc [NV];
  int stall_left = 0;
  logic [IW-1:0] stall_idx = '0;

  function automatic vertex_3d_t scene(input logic [1:0] m, input int k);
    vertex_3d_t v;
    v.x = 16'(100 * int'(m) + 3 * k + 1);
    v.y = 16'(7 * k - 20);
    v.z = 16'(k + 5 + 10 * int'(m));
    return v;
  endfunction

  function automatic vertex_2d_t proj(input vertex_3d_t v);
    vertex_2d_t p;
    p.x = v.x;
    p.y = v.y + v.z;
    return p;
  endfunction

  assign vtx_rd_data = scene(cfg_model_select, int'(vtx_rd_idx));

  vertex_sequencer #(.NUM_VERTS(NV), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .frame(frame), .model_sel_in(model_sel_in),
    .angle_x_in(angle_x_in), .angle_y_in(angle_y_in), .angle_z_in(angle_z_in),
    .cfg_model_select(cfg_model_select), .vtx_rd_idx(vtx_rd_idx),
    .vtx_rd_data(vtx_rd_data), .xf_in_valid(xf_in_valid), .xf_ready(xf_ready),
    .xf_in_vert(xf_in_vert), .xf_in_idx(xf_in_idx), .xf_angle_x(xf_angle_x),
    .xf_angle_y(xf_angle_y), .xf_angle_z(xf_angle_z),
    .xf_out_valid(xf_out_valid), .xf_out_idx(xf_out_idx),
    .xf_out_vert(xf_out_vert), .rd_idx(rd_idx), .rd_vert(rd_vert),
    .busy(busy), .done(done), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge (+1), sample handshakes (+2).
  task automatic step(input bit fr);
    exp_t e;
    res_t r;
    @(negedge clk); #1;
    cyc++;
    frame    = fr;
    xf_ready = 1'b1;
    if (xf_in_valid && xf_in_idx == stall_idx && stall_left > 0) begin
      xf_ready = 1'b0;
      stall_left--;
      if (sb.size() > 0) chk("stall_hold_vert", 64'(xf_in_vert), 64'(sb[0].v));
    end
    xf_out_valid = 1'b0;
    xf_out_idx   = '0;
    xf_out_vert  = '0;
    if (ooo) begin
      if (pend.size() == NV) ooo_emit = 1'b1;
      if (ooo_emit && pend.size() > 0) begin
        r = pend.pop_back();
        xf_out_valid = 1'b1; xf_out_idx = r.idx; xf_out_vert = r.v;
      end
      if (pend.size() == 0) ooo_emit = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      xf_out_valid = 1'b1; xf_out_idx = r.idx; xf_out_vert = r.v;
    end
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      chk("busy_low_with_done", 64'(busy), 64'(0));
    end
    #1;
    if (xf_in_valid && xf_ready) begin
      issue_cyc[xf_in_idx] = cyc;
      if (sb.size() == 0) chk("issue_expected", 64'(sb.size()), 64'(1));
      else begin
        e = sb.pop_front();
        chk("issue_idx", 64'(xf_in_idx), 64'(e.idx));
        chk("issue_vert", 64'(xf_in_vert), 64'(e.v));
      end
      r.idx = xf_in_idx; r.v = proj(xf_in_vert); r.due = cyc + LAT;
      pend.push_back(r);
    end
  endtask

  task automatic start_frame(input logic [1:0] m, input int ax, input int ay, input int az);
    exp_t e;
    model_sel_in = m;
    angle_x_in = 16'(ax); angle_y_in = 16'(ay); angle_z_in = 16'(az);
    sb.delete();
    for (int k = 0; k < NV; k++) begin
      e.idx = IW'(k); e.v = scene(m, k);
      sb.push_back(e);
    end
    done_seen = 1'b0;
    step(1'b1);
    t0 = cyc;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      step(1'b0);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_seen), 64'(1));
  endtask

  task automatic check_front(input string tag, input bit zero, input logic [1:0] m);
    vertex_2d_t ex;
    for (int k = 0; k < NV; k++) begin
      rd_idx = IW'(k);
      #1;
      ex = zero ? '0 : proj(scene(m, k));
      chk(tag, 64'(rd_vert), 64'(ex));
    end
  endtask

  initial begin
    rst = 1'b1; frame = 1'b0; model_sel_in = '0;
    angle_x_in = '0; angle_y_in = '0; angle_z_in = '0;
    xf_ready = 1'b1; xf_out_valid = 1'b0; xf_out_idx = '0; xf_out_vert = '0;
    rd_idx = '0;
    repeat (3) step(1'b0);
    rst = 1'b0;
    step(1'b0);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_in_valid", 64'(xf_in_valid), 64'(0));
    chk("rst_model", 64'(cfg_model_select), 64'(0));
    chk("rst_angle_x", 64'(xf_angle_x), 64'(0));
    check_front("rst_front", 1'b1, 2'd0);

    // Ideal transform, L=3, angle change mid-batch
    start_frame(2'd1, 7, 2, 3);
    step(1'b0);
    chk("a_busy", 64'(busy), 64'(1));
    chk("a_in_valid", 64'(xf_in_valid), 64'(1));
    chk("a_model", 64'(cfg_model_select), 64'(1));
    chk("a_angle_z", 64'(xf_angle_z), 64'(3));
    repeat (3) step(1'b0);
    angle_x_in = 16'sd14;
    repeat (2) step(1'b0);
    chk("a_angle_hold", 64'(xf_angle_x), 64'(7));
    run_until_done("a", 40);
    chk("a_done_cyc", 64'(done_cyc), 64'(t0 + 12));
    for (int k = 0; k < NV; k++) chk("a_issue_cyc", 64'(issue_cyc[k]), 64'(t0 + 1 + k));
    check_front("a_front_still_zero", 1'b1, 2'd0);

    // Swap + backpressure at index 3 for 4 cycles
    stall_idx = 3'd3; stall_left = 4;
    start_frame(2'd2, 14, 4, 5);
    step(1'b0);
    chk("b_angle_x", 64'(xf_angle_x), 64'(14));
    rd_idx = 3'd5; #1;
    chk("b_rd5", 64'(rd_vert), 64'(proj(scene(2'd1, 5))));
    check_front("b_swap", 1'b0, 2'd1);
    run_until_done("b", 60);
    chk("b_done_cyc", 64'(done_cyc), 64'(t0 + 16));
    chk("b_stall_used", 64'(stall_left), 64'(0));

    // Out-of-order results: tags 7..0
    ooo = 1'b1;
    start_frame(2'd3, 1, 1, 1);
    step(1'b0);
    check_front("c_swap", 1'b0, 2'd2);
    run_until_done("c", 60);
    chk("c_done_cyc", 64'(done_cyc), 64'(t0 + 17));
    ooo = 1'b0;

    // Overrun in DRAIN and on the final-writeback cycle
    start_frame(2'd0, 5, 6, 7);
    step(1'b0);
    check_front("d_swap_ooo", 1'b0, 2'd3);
    repeat (7) step(1'b0);
    angle_x_in = 16'sd99; model_sel_in = 2'd3;
    step(1'b1);
    step(1'b0);
    chk("d_overrun", 64'(overrun), 64'(1));
    chk("d_angle_kept", 64'(xf_angle_x), 64'(5));
    chk("d_model_kept", 64'(cfg_model_select), 64'(0));
    step(1'b1);
    run_until_done("d", 10);
    chk("d_done_cyc", 64'(done_cyc), 64'(t0 + 12));
    check_front("d_no_swap", 1'b0, 2'd3);

    // Next accepted frame swaps normally; then reset mid-ISSUE
    start_frame(2'd3, 99, 0, 0);
    step(1'b0);
    check_front("e_swap", 1'b0, 2'd0);
    chk("e_angle_x", 64'(xf_angle_x), 64'(99));
    chk("e_overrun_sticky", 64'(overrun), 64'(1));
    step(1'b0);
    rst = 1'b1;
    pend.delete();
    sb.delete();
    step(1'b0);
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_overrun", 64'(overrun), 64'(0));
    chk("mid_rst_in_valid", 64'(xf_in_valid), 64'(0));
    check_front("mid_rst_front", 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", ntest);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vertex_sequencer.md
# vertex_sequencer

Time-multiplexes a single shared rotate+project transform unit across all model vertices, replacing one transform instance per vertex. Starts on each `frame` pulse and latches the model and rotation angles for the whole batch. Writes projected vertices into a double-buffered 2D vertex store and serves the stable front bank to the rasterizer for the entire frame. Sits between scene_objects and the transform unit on the input side, and feeds the rasterizer's vertex read port.

## Interface
Parameters:
- `NUM_VERTS`, default 8: vertices per model.
- `IDX_W`, default 3: vertex index width, equal to clog2(NUM_VERTS).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `frame` in 1: one-cycle start-of-frame pulse from vga_timing.
- `model_sel_in` in 2: requested model.
- `angle_x_in`, `angle_y_in`, `angle_z_in` in 16 signed: requested rotation.
- `cfg_model_select` out 2: latched model, driven to scene_objects.
- `vtx_rd_idx` out IDX_W: scene vertex read index.
- `vtx_rd_data` in vertex_3d_t: combinational read of `vtx_rd_idx`.
- `xf_in_valid` out 1, `xf_ready` in 1: issue handshake to the transform unit.
- `xf_in_vert` out vertex_3d_t, `xf_in_idx` out IDX_W: issued vertex and its tag.
- `xf_angle_x`, `xf_angle_y`, `xf_angle_z` out 16 signed: latched angles.
- `xf_out_valid` in 1, `xf_out_idx` in IDX_W, `xf_out_vert` in vertex_2d_t: transform results, in any order.
- `rd_idx` in IDX_W: rasterizer read index.
- `rd_vert` out vertex_2d_t: front-bank vertex, combinational from `rd_idx`.
- `busy` out 1: batch in flight.
- `done` out 1: one-cycle pulse when a batch completes.
- `overrun` out 1: sticky flag; cleared only by `rst`.

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
- **IDLE.** On `frame`:
  - Latch the angles into `xf_angle_*` and `model_sel_in` into `cfg_model_select`.
  - If `back_valid` is set, toggle `front_sel` and clear `back_valid`.
  - Clear `issue_cnt` and `wr_cnt`, then go to ISSUE.
- **ISSUE.**
  - Drive `vtx_rd_idx = xf_in_idx = issue_cnt`, `xf_in_vert = vtx_rd_data` and `xf_in_valid = 1`.
  - Increment `issue_cnt` on `xf_in_valid && xf_ready`.
  - Go to DRAIN after index NUM_VERTS-1 is accepted.
  - Inputs must be held while `xf_ready` is low.
- **Writeback (ISSUE and DRAIN).** On `xf_out_valid`:
  - Write `xf_out_vert` to the back bank at `xf_out_idx`.
  - Increment `wr_cnt` (width IDX_W+1).
- **DRAIN.** When `wr_cnt == NUM_VERTS`: pulse `done`, set `back_valid`, return to IDLE.
- **Ignored results.** Writeback with `xf_out_valid` in IDLE is dropped, with no count and no write.
- **`frame` while busy.**
  - Covers ISSUE, DRAIN, and the DRAIN cycle in which the final writeback lands.
  - Sets `overrun`.
  - No latch and no swap; the running batch finishes.
  - The next `frame` performs the swap.
- **Front bank stability.** The front bank is never written. Swap happens only on a `frame` accepted in IDLE.
- **Reset values:**
  - FSM = IDLE.
  - `front_sel`, `back_valid`, counters = 0.
  - Both banks = 0.
  - `cfg_model_select` and `xf_angle_*` = 0.
  - `xf_in_valid`, `busy`, `done`, `overrun` = 0.
- **Reset mid-batch.** Aborts the batch: partial back-bank data is discarded and the front bank is zeroed.

## Timing
- `frame` accepted at cycle T:
  - `busy` = 1 and `xf_in_valid` = 1 (index 0) at T+1.
  - A swap is visible on `rd_vert` at T+1.
- With `xf_ready` = 1 throughout, index k issues at T+1+k, and the last issue is at T+NUM_VERTS.
- With transform latency L, the last result arrives at T+NUM_VERTS+L. `done` is high in the following cycle and `busy` drops with it.
- Each `xf_ready` low cycle delays all later issues by one cycle.
- `rd_vert` has zero latency.
- Registered outputs (`xf_angle_*`, `cfg_model_select`) stay constant from T+1 until the next accepted `frame`.

## Structure
- `vertex_3d_t` and `vertex_2d_t` stay in the shared graphics_type package.
- The FSM state enum is local to this block.
- One sub-module, `vertex_bank`, holds:
  - two NUM_VERTS × vertex_2d_t arrays;
  - a write port into bank `!front_sel`;
  - a combinational read port from bank `front_sel`;
  - synchronous zeroing on `rst`.

## Test plan
- **Ideal transform.** Reset, then `frame` with `xf_ready` = 1 and an ideal L=3 model (output = tagged input) → indices 0..7 issued on cycles T+1..T+8, `done` at T+12, `back_valid` set, front bank still zero; the next `frame` swaps, and `rd_idx` = 5 returns vertex 5's projection.
- **Backpressure.** Same as above but `xf_ready` is low for 4 cycles at index 3 → index 3 and its inputs are held; `done` is delayed by exactly 4 cycles.
- **Out-of-order results.** The model returns tags 7..0 → all 8 land at the correct addresses and `done` fires after the 8th write.
- **Overrun.** `frame` in DRAIN, including the final-writeback cycle → `overrun` = 1, angles are not re-latched and there is no swap; the following `frame` swaps normally.
- **Reset mid-batch.** `rst` in ISSUE → next cycle FSM = IDLE, `busy` = 0, `overrun` = 0, `rd_vert` = 0 for all indices.
- **Angle latching.** Change `angle_x_in` from 7 to 14 mid-batch → `xf_angle_x` stays 7 until the next accepted `frame`.
